// File: rtl/cordic_apb_regif.sv
// rtl/cordic_apb_regif.sv - APB3 register interface and result FIFO for the CORDIC engine; optional CORDIC_REGIF_SLVERR_EN error responses
module cordic_apb_regif #(
   parameter int NUM_IN     = 4,
   parameter int NUM_OUT    = 6,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [7:0]                PADDR,
   input  logic [31:0]               PWDATA,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic                      cordic_busy,
   input  logic                      cordic_done,
   input  logic [NUM_OUT*DATA_W-1:0] cordic_out,
   output logic                      cordic_start,
   output logic [2:0]                mode,
   output logic [NUM_IN*DATA_W-1:0]  prog,
   output logic [4:0]                xyfracbase,
   output logic [4:0]                phasefracbase,
   output logic                      INT
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = NUM_OUT * DATA_W;

   typedef enum logic {S_IDLE, S_HOLD} state_t;
   state_t state, state_nx;

   logic [5:0]         word;
   logic [NUM_IN-1:0]  prog_hit;
   logic [NUM_OUT-1:0] res_hit;
   logic               sel_ctrl, sel_status, sel_frac, sel_prog, sel_res, mapped;
   logic               access, err, xfer_done, wr_done, rd_done;

   logic [2:0]              mode_q;
   logic                    ie_done, ie_ovf;
   logic [4:0]              xy_q, ph_q;
   logic [NUM_IN*DATA_W-1:0] prog_q;
   logic                    start_q, int_q, ovf_q, done_q;

   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          empty, full, push, pop, ovf_set;
   logic [EW-1:0] head;

   logic [31:0] hold_data, res_word, status_word;
   logic        hold_ok;
   logic        unused_bits;

   assign word        = PADDR[7:2];
   assign access      = PSEL & PENABLE;
   assign unused_bits = ^{PADDR[1:0], PWDATA};

   // address decode into register selects
   always_comb begin
      prog_hit = '0;
      res_hit  = '0;
      for (int i = 0; i < NUM_IN; i++)  prog_hit[i] = (word == 6'(4 + i));
      for (int j = 0; j < NUM_OUT; j++) res_hit[j]  = (word == 6'(16 + j));
      sel_ctrl   = (word == 6'd0);
      sel_status = (word == 6'd1);
      sel_frac   = (word == 6'd2);
      sel_prog   = |prog_hit;
      sel_res    = |res_hit;
      mapped     = sel_ctrl | sel_status | sel_frac | sel_prog | sel_res;
   end

`ifdef CORDIC_REGIF_SLVERR_EN
   assign err = access & (~mapped
                          | (PWRITE & sel_status & (|(PWDATA & ~32'h0000_0018)))
                          | (PWRITE & sel_res));
`else
   assign err = 1'b0;
`endif

   // RES reads take one wait state so the head word can be registered
   always_comb begin
      state_nx = state;
      PREADY   = 1'b1;
      case (state)
         S_IDLE: begin
            if (access && !PWRITE && sel_res) begin
               PREADY   = 1'b0;
               state_nx = S_HOLD;
            end
         end
         S_HOLD: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // transfer state register
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= S_IDLE;
      else        state <= state_nx;
   end

   assign xfer_done = access & PREADY;
   assign wr_done   = xfer_done & PWRITE & ~err;
   assign rd_done   = xfer_done & ~PWRITE;
   assign PSLVERR   = err & PREADY;

   assign head    = fifo_mem[rd_ptr];
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign pop     = (state == S_HOLD) & rd_done & res_hit[NUM_OUT-1] & hold_ok;
   assign push    = cordic_done & (~full | pop);
   assign ovf_set = cordic_done & full & ~pop;

   // head word selected by the RES index, and the STATUS image
   always_comb begin
      res_word = '0;
      if (!empty) begin
         for (int j = 0; j < NUM_OUT; j++)
            if (res_hit[j]) res_word[DATA_W-1:0] = head[j*DATA_W +: DATA_W];
      end
      status_word       = '0;
      status_word[0]    = cordic_busy;
      status_word[1]    = empty;
      status_word[2]    = full;
      status_word[3]    = ovf_q;
      status_word[4]    = done_q;
      status_word[12:8] = 5'(count);
   end

   // read data is driven only while a read completes
   always_comb begin
      PRDATA = '0;
      if (rd_done) begin
         if (state == S_HOLD)  PRDATA = hold_data;
         else if (sel_ctrl)    PRDATA[5:0] = {ie_ovf, ie_done, mode_q, 1'b0};
         else if (sel_status)  PRDATA = status_word;
         else if (sel_frac) begin
            PRDATA[4:0]  = xy_q;
            PRDATA[12:8] = ph_q;
         end else begin
            for (int i = 0; i < NUM_IN; i++)
               if (prog_hit[i]) PRDATA[DATA_W-1:0] = prog_q[i*DATA_W +: DATA_W];
         end
      end
   end

   // capture the head word in the wait-state cycle of a RES read
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         hold_data <= '0;
         hold_ok   <= 1'b0;
      end else if (state == S_IDLE && access && !PWRITE && sel_res) begin
         hold_data <= res_word;
         hold_ok   <= ~empty;
      end
   end

   // result storage, written on every accepted push
   always_ff @(posedge PCLK) begin
      if (push) fifo_mem[wr_ptr] <= cordic_out;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // control, format and operand registers plus the start pulse
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         mode_q  <= '0;
         ie_done <= 1'b0;
         ie_ovf  <= 1'b0;
         xy_q    <= 5'd16;
         ph_q    <= 5'd28;
         prog_q  <= '0;
         start_q <= 1'b0;
      end else begin
         start_q <= wr_done & sel_ctrl & PWDATA[0] & ~cordic_busy;
         if (wr_done && sel_ctrl) begin
            mode_q  <= PWDATA[3:1];
            ie_done <= PWDATA[4];
            ie_ovf  <= PWDATA[5];
         end
         if (wr_done && sel_frac) begin
            xy_q <= PWDATA[4:0];
            ph_q <= PWDATA[12:8];
         end
         for (int i = 0; i < NUM_IN; i++)
            if (wr_done && prog_hit[i]) prog_q[i*DATA_W +: DATA_W] <= PWDATA[DATA_W-1:0];
      end
   end

   // sticky flags: a set event beats a same-cycle W1C
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
         int_q  <= 1'b0;
      end else begin
         ovf_q  <= ovf_set | (ovf_q & ~(wr_done & sel_status & PWDATA[3]));
         done_q <= cordic_done | (done_q & ~(wr_done & sel_status & PWDATA[4]));
         int_q  <= (done_q & ie_done) | (ovf_q & ie_ovf);
      end
   end

   assign cordic_start  = start_q;
   assign mode          = mode_q;
   assign prog          = prog_q;
   assign xyfracbase    = xy_q;
   assign phasefracbase = ph_q;
   assign INT           = int_q;
endmodule

// File: tb/tb_cordic_apb_regif.sv
// tb/tb_cordic_apb_regif.sv - scoreboard testbench for cordic_apb_regif with a register-map reference model
`timescale 1ns/1ps
module tb_cordic_apb_regif;
   localparam int NI = 4;
   localparam int NO = 6;
   localparam int DW = 32;
   localparam int FD = 4;

   typedef logic [NO-1:0][31:0] entry_t;
   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        err;
   } sb_t;

   logic              PCLK = 1'b0;
   logic              PRESET, PSEL, PENABLE, PWRITE;
   logic [7:0]        PADDR;
   logic [31:0]       PWDATA, PRDATA;
   logic              PREADY, PSLVERR;
   logic              cordic_busy, cordic_done, cordic_start;
   logic [NO*DW-1:0]  cordic_out;
   logic [2:0]        mode;
   logic [NI*DW-1:0]  prog;
   logic [4:0]        xyfracbase, phasefracbase;
   logic              INT;

   cordic_apb_regif #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .cordic_busy(cordic_busy), .cordic_done(cordic_done), .cordic_out(cordic_out),
      .cordic_start(cordic_start), .mode(mode), .prog(prog),
      .xyfracbase(xyfracbase), .phasefracbase(phasefracbase), .INT(INT)
   );

   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad = 0;
   int start_cnt = 0;
   int exp_starts = 0;
   sb_t sb_q[$];

   logic [2:0]  m_mode = 3'd0;
   logic        m_ie_done = 1'b0, m_ie_ovf = 1'b0, m_ovf = 1'b0, m_done = 1'b0;
   logic [4:0]  m_xy = 5'd16, m_ph = 5'd28;
   logic [31:0] m_prog [NI];
   entry_t      m_fifo[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic bit is_res(input logic [7:0] a);
      int w;
      w = int'(a[7:2]);
      return (w >= 16 && w < 16 + NO);
   endfunction

   function automatic logic exp_err(input logic wr, input logic [7:0] a, input logic [31:0] d);
`ifdef CORDIC_REGIF_SLVERR_EN
      int w;
      w = int'(a[7:2]);
      if (!(w <= 2 || (w >= 4 && w < 4 + NI) || is_res(a))) return 1'b1;
      if (wr && w == 1 && (d & ~32'h18) != 0) return 1'b1;
      if (wr && is_res(a)) return 1'b1;
      return 1'b0;
`else
      return (wr & 1'b0) | (a[0] & 1'b0) | (d[0] & 1'b0);
`endif
   endfunction

   function automatic logic [31:0] model_rd(input logic [7:0] a);
      int w;
      logic [31:0] r;
      w = int'(a[7:2]);
      r = '0;
      if (w == 0) r[5:0] = {m_ie_ovf, m_ie_done, m_mode, 1'b0};
      else if (w == 1) begin
         r[0]    = cordic_busy;
         r[1]    = (m_fifo.size() == 0);
         r[2]    = (m_fifo.size() == FD);
         r[3]    = m_ovf;
         r[4]    = m_done;
         r[12:8] = 5'(m_fifo.size());
      end else if (w == 2) begin
         r[4:0]  = m_xy;
         r[12:8] = m_ph;
      end else if (w >= 4 && w < 4 + NI) r = m_prog[w-4];
      else if (is_res(a) && m_fifo.size() > 0) r = m_fifo[0][w-16];
      return r;
   endfunction

   function automatic void model_commit(input logic wr, input logic [7:0] a, input logic [31:0] d);
      int w;
      w = int'(a[7:2]);
      if (exp_err(wr, a, d)) return;
      if (wr) begin
         if (w == 0) begin
            m_mode = d[3:1]; m_ie_done = d[4]; m_ie_ovf = d[5];
            if (d[0] && !cordic_busy) exp_starts++;
         end else if (w == 1) begin
            if (d[3]) m_ovf = 1'b0;
            if (d[4]) m_done = 1'b0;
         end else if (w == 2) begin
            m_xy = d[4:0]; m_ph = d[12:8];
         end else if (w >= 4 && w < 4 + NI) m_prog[w-4] = d;
      end else if (w == 16 + NO - 1 && m_fifo.size() > 0) begin
         void'(m_fifo.pop_front());
      end
   endfunction

   function automatic void model_push(input entry_t e);
      if (m_fifo.size() < FD) m_fifo.push_back(e);
      else m_ovf = 1'b1;
      m_done = 1'b1;
   endfunction

   function automatic entry_t rnd_entry();
      entry_t e;
      for (int j = 0; j < NO; j++) e[j] = $urandom;
      return e;
   endfunction

   task automatic settle();
      @(posedge PCLK); #1;
   endtask

   task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic with_done, input entry_t dw);
      int waits, expw;
      sb_t e;
      e.addr = a;
      e.data = wr ? 32'h0 : model_rd(a);
      e.err  = exp_err(wr, a, d);
      expw   = (!wr && is_res(a)) ? 1 : 0;
      sb_q.push_back(e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits = 0;
      @(negedge PCLK);
      while (!PREADY && waits < 4) begin
         waits++;
         @(negedge PCLK);
      end
      if (with_done) begin
         cordic_out  = dw;
         cordic_done = 1'b1;
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; cordic_done = 1'b0;
      chk($sformatf("waits@%h", a), 32'(waits), 32'(expw));
      model_commit(wr, a, d);
      if (with_done) model_push(dw);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      apb(1'b1, a, d, 1'b0, '0);
   endtask

   task automatic rd(input logic [7:0] a);
      apb(1'b0, a, 32'h0, 1'b0, '0);
   endtask

   task automatic pulse_done(input entry_t e);
      @(posedge PCLK); #1;
      cordic_out = e; cordic_done = 1'b1;
      @(posedge PCLK); #1;
      cordic_done = 1'b0;
      model_push(e);
   endtask

   task automatic check_int();
      settle();
      chk("int", 32'(INT), 32'((m_done & m_ie_done) | (m_ovf & m_ie_ovf)));
   endtask

   // monitor: every completing transfer is compared against the scoreboard head
   always @(negedge PCLK) begin
      sb_t e;
      if (cordic_start === 1'b1) start_cnt++;
      if (PRESET === 1'b0 && PSEL === 1'b1 && PENABLE === 1'b1 && PREADY === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected: got transfer at %h want none", PADDR);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("prdata@%h", e.addr), PRDATA, e.data);
            chk($sformatf("pslverr@%h", e.addr), 32'(PSLVERR), 32'(e.err));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      entry_t e;
      int op, w;
      for (int i = 0; i < NI; i++) m_prog[i] = '0;
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      cordic_busy = 1'b0; cordic_done = 1'b0; cordic_out = '0;
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b0;
      #1;
      chk("rst_int", 32'(INT), 32'd0);
      chk("rst_pready", 32'(PREADY), 32'd1);
      chk("rst_pslverr", 32'(PSLVERR), 32'd0);
      chk("rst_start", 32'(cordic_start), 32'd0);
      chk("rst_prdata", PRDATA, 32'd0);
      rd(8'h08);
      rd(8'h04);

      wr(8'h10, 32'h1234_5678);
      rd(8'h10);
      wr(8'h00, 32'h13);
      settle();
      chk("start_cnt", 32'(start_cnt), 32'(exp_starts));
      chk("mode", 32'(mode), 32'd1);
      rd(8'h00);
      cordic_busy = 1'b1;
      wr(8'h00, 32'h13);
      cordic_busy = 1'b0;
      settle();
      chk("start_busy", 32'(start_cnt), 32'(exp_starts));

      e = rnd_entry();
      e[0] = 32'hA5;
      pulse_done(e);
      chk("int_lag", 32'(INT), 32'd0);
      settle();
      chk("int_rise", 32'(INT), 32'd1);
      rd(8'h04);
      wr(8'h04, 32'h10);
      settle();
      chk("int_fall", 32'(INT), 32'd0);

      for (int j = 0; j < NO; j++) begin
         rd(8'(8'h40 + 4*j));
         if (j == 2 || j == NO - 1) rd(8'h04);
      end
      rd(8'h54);
      rd(8'h04);

      wr(8'h00, 32'h30);
      for (int k = 0; k < 5; k++) pulse_done(rnd_entry());
      rd(8'h04);
      check_int();
      for (int j = 0; j < NO; j++) rd(8'(8'h40 + 4*j));
      rd(8'h04);
      wr(8'h04, 32'h18);
      pulse_done(rnd_entry());
      rd(8'h04);
      for (int j = 0; j < NO - 1; j++) rd(8'(8'h40 + 4*j));
      apb(1'b0, 8'h54, 32'h0, 1'b1, rnd_entry());
      rd(8'h04);
      for (int j = 0; j < NO; j++) rd(8'(8'h40 + 4*j));

      wr(8'h3C, $urandom);
      wr(8'h40, 32'hDEAD_BEEF);
      rd(8'h40);
      wr(8'h04, 32'h01);
      rd(8'h04);
      rd(8'h0C);

      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 9);
         cordic_busy = 1'($urandom_range(0, 1));
         case (op)
            0, 1: pulse_done(rnd_entry());
            2: wr(8'h00, 32'($urandom_range(0, 63)));
            3: wr(8'h04, ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h18));
            4: begin
               w = $urandom_range(0, 23);
               wr(8'(4*w), $urandom);
            end
            default: begin
               w = (op >= 7) ? 16 + $urandom_range(0, NO - 1) : $urandom_range(0, 23);
               rd(8'(4*w));
            end
         endcase
         check_int();
      end

      cordic_busy = 1'b0;
      settle();
      chk("start_total", 32'(start_cnt), 32'(exp_starts));
      chk("mode_out", 32'(mode), 32'(m_mode));
      chk("xy_out", 32'(xyfracbase), 32'(m_xy));
      chk("ph_out", 32'(phasefracbase), 32'(m_ph));
      for (int i = 0; i < NI; i++) chk($sformatf("prog_out%0d", i), prog[i*DW +: DW], m_prog[i]);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cordic_apb_regif.md
# cordic_apb_regif

Parametrised APB3 register interface for the CORDIC engine, successor to the fixed six-output register block. Holds the input operand registers, mode/control, and fractional-format registers; captures CORDIC results into a result FIFO so back-to-back computations are not lost. Sits between the APB bus and the CORDIC datapath. Adds wait states, error response, sticky W1C status, and a masked interrupt.

## Interface
- NUM_IN, 4: operand registers PROG_0..PROG_{NUM_IN-1}, 1..8
- NUM_OUT, 6: result words per computation, 1..8
- DATA_W, 32: operand/result width, 8..32
- FIFO_DEPTH, 4: result entries, power of 2, 2..16
- PCLK  in  1  clock
- PRESET  in  1  reset; asynchronous, active-high
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control
- PADDR  in  8  byte address; bits [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response
- cordic_busy  in  1  engine computing
- cordic_done  in  1  one-cycle pulse: result valid on cordic_out
- cordic_out  in  NUM_OUT*DATA_W  result j at bits [j*DATA_W +: DATA_W]
- cordic_start  out  1  one-cycle start pulse
- mode  out  3  CTRL[3:1]
- prog  out  NUM_IN*DATA_W  operand registers, flattened
- xyfracbase, phasefracbase  out  5 each  format registers
- INT  out  1  level interrupt

## Operation
- Register map:
  - 0x00 CTRL: [0] START (W1, reads 0), [3:1] MODE, [4] IE_DONE, [5] IE_OVF.
  - 0x04 STATUS (RO except W1C): [0] BUSY, [1] EMPTY, [2] FULL, [3] OVF (W1C), [4] DONE (W1C), [12:8] LEVEL.
  - 0x08 FRAC: [4:0] XY, [12:8] PHASE.
  - 0x10+4i PROG_i, i<NUM_IN: R/W, low DATA_W bits.
  - 0x40+4j RES_j, j<NUM_OUT: RO, FIFO head word j zero-extended; reads 0 when EMPTY.
- START write with PWDATA[0]=1 and cordic_busy=0 → cordic_start high one cycle. If busy, ignored, no flag.
- cordic_done pushes all NUM_OUT words as one entry and sets DONE.
- FULL with no simultaneous pop → entry dropped, OVF set, FIFO unchanged. Push and pop in the same cycle while full → both occur, no OVF.
- Completed read of RES_{NUM_OUT-1} pops the head entry; no pop when EMPTY. Other RES reads do not pop.
- W1C and a set event in the same cycle → set wins.
- INT = (DONE & IE_DONE) | (OVF & IE_OVF).
- Reset values:
  - Registers: CTRL 0, PROG 0, XY 16, PHASE 28, FIFO empty, OVF/DONE 0.
  - Outputs: PRDATA 0, PREADY 1, PSLVERR 0, cordic_start 0, INT 0.

## Timing
- Setup phase (PSEL=1, PENABLE=0): no side effects.
- Non-RES accesses: PREADY=1 in the first access cycle; zero wait states. Writes commit on that edge.
- RES reads: exactly one wait state. PREADY=0 in the first access cycle, head word registered. PREADY=1 in the second cycle with data valid; pop occurs on that edge.
- PRDATA is 0 whenever no read is completing.
- cordic_start asserts the cycle after the CTRL write completes.
- A push is visible in STATUS/RES the cycle after cordic_done.
- INT is registered; it rises one cycle after the flag sets.
- Reset asserted mid-transfer: all state returns to reset values immediately; the transfer is abandoned.

## Configuration
- CORDIC_REGIF_SLVERR_EN defined: PSLVERR=1 with PREADY=1 on the following accesses, with no state change:
  - unmapped address;
  - write to STATUS bits other than [4:3];
  - write to RES_j.
- Undefined: PSLVERR is tied 0. Unmapped and read-only writes are silently ignored, and unmapped reads return 0.

## Test plan
- Reset: read FRAC → 0x0000_1C10; STATUS → 0x0000_0002; INT=0; PREADY=1.
- Write PROG_0=0x1234_5678, CTRL=0x13 with busy=0 → one cordic_start pulse, mode=1; CTRL readback 0x12. Pulse cordic_done with RES_0=0xA5 → DONE=1, INT=1; write STATUS 0x10 → INT falls.
- Five cordic_done pulses with FIFO_DEPTH=4 and no reads → LEVEL=4, FULL=1, OVF=1. The fifth entry is lost; the first entry is read back intact.
- Read RES_0..RES_5 → each read has exactly one PREADY=0 cycle; LEVEL decrements only after RES_5. A read with EMPTY returns 0 and LEVEL stays 0.
- Full FIFO, cordic_done in the same cycle as the completing RES_5 read → LEVEL stays 4, OVF stays 0.
- With CORDIC_REGIF_SLVERR_EN: write 0x3C → PSLVERR=1; write RES_0 → PSLVERR=1, contents unchanged. Without the macro: PSLVERR stays 0 for both.
